// File: rtl/oric_bus_pkg.sv
// oric_bus_pkg: shared Oric bus types, read-source indices and defaults.
package oric_bus_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} rdmux_state_t;
  localparam logic [31:0] NONE_IDX = '1;
  localparam int DW_DEF = 8;
  localparam logic [7:0] OPEN_BUS_VAL_DEF = 8'hFF;
  localparam int SRC_EXP = 0;
  localparam int SRC_VIA = 1;
  localparam int SRC_ROM_MD = 2;
  localparam int SRC_ROM_ATMOS = 3;
  localparam int SRC_ROM_1 = 4;
  localparam int SRC_RAM = 5;
endpackage

// File: rtl/oric_prio_enc.sv
// oric_prio_enc: lowest-index priority encoder; sel_i -> idx_o (all-ones if none), any_o, multi_o.
module oric_prio_enc #(
  parameter int N = 8,
  parameter int IW = $clog2(N) + 1
) (
  input  logic [N-1:0]  sel_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o,
  output logic          multi_o
);
  always_comb begin
    idx_o = '1;
    for (int i = N - 1; i >= 0; i--) if (sel_i[i]) idx_o = IW'(i);
  end
  assign any_o = |sel_i;
  assign multi_o = |(sel_i & (sel_i - N'(1)));
endmodule

// File: rtl/oric_cpu_rdmux.sv
// oric_cpu_rdmux: CPU read-data collector; locks one of NSRC sources per phi2 phase and drives cpu_di, rd_src, conflict, rd_timeout.
module oric_cpu_rdmux import oric_bus_pkg::*; #(
  parameter int NSRC = 8,
  parameter int DW = DW_DEF,
  parameter int OPEN_BUS_HOLD = 1,
  parameter logic [DW-1:0] OPEN_BUS_VAL = DW'(OPEN_BUS_VAL_DEF),
  parameter int WRITE_TRACK = 1,
  localparam int IW = $clog2(NSRC) + 1
) (
  input  logic             CLK_IN,
  input  logic             RESET,
  input  logic             phi2,
  input  logic             phi2_en,
  input  logic             cpu_rw,
  input  logic [DW-1:0]    cpu_do,
  input  logic [NSRC-1:0]  src_sel,
  input  logic [NSRC-1:0]  src_valid,
  input  logic [NSRC*DW-1:0] src_data,
  output logic [DW-1:0]    cpu_di,
  output logic [IW-1:0]    rd_src,
  output logic             conflict,
  output logic             rd_timeout
);
  localparam int NX = 1 << IW;
  localparam logic [IW-1:0] NONE = IW'(NONE_IDX);
  rdmux_state_t state_q, state_d;
  logic phi2_q;
  logic [DW-1:0] cpu_di_q, cpu_di_d, ob_val, dat;
  logic [IW-1:0] rd_src_q, rd_src_d, enc_idx, cur;
  logic conflict_q, conflict_d, rd_timeout_q, rd_timeout_d;
  logic enc_any, enc_multi, lock, vld;
  logic [NX-1:0] vld_x;
  logic [DW-1:0] dat_a [NX];
  oric_prio_enc #(.N(NSRC), .IW(IW)) u_enc (
    .sel_i(src_sel), .idx_o(enc_idx), .any_o(enc_any), .multi_o(enc_multi)
  );
  assign vld_x = {{(NX - NSRC){1'b0}}, src_valid};
  for (genvar g = 0; g < NX; g++) begin : g_dat
    if (g < NSRC) begin : g_src
      assign dat_a[g] = src_data[g*DW +: DW];
    end else begin : g_pad
      assign dat_a[g] = '0;
    end
  end
  assign lock = phi2 & ~phi2_q;
  assign cur = (state_q == IDLE) ? enc_idx : rd_src_q;
  assign vld = vld_x[cur];
  assign dat = dat_a[cur];
  assign ob_val = (OPEN_BUS_HOLD != 0) ? cpu_di_q : OPEN_BUS_VAL;
  always_comb begin
    state_d = state_q;
    cpu_di_d = cpu_di_q;
    rd_src_d = rd_src_q;
    conflict_d = 1'b0;
    rd_timeout_d = 1'b0;
    case (state_q)
      IDLE: if (lock) begin
        if (!cpu_rw) begin
          state_d = DONE;
          rd_src_d = NONE;
          cpu_di_d = (WRITE_TRACK != 0) ? cpu_do : cpu_di_q;
        end else begin
          rd_src_d = enc_idx;
          conflict_d = enc_multi;
          state_d = (!enc_any || vld || phi2_en) ? DONE : WAIT;
          cpu_di_d = (enc_any && vld) ? dat : (!enc_any || phi2_en) ? ob_val : cpu_di_q;
          rd_timeout_d = enc_any && !vld && phi2_en;
        end
      end
      WAIT: if (vld || !phi2 || phi2_en) begin
        state_d = phi2 ? DONE : IDLE;
        cpu_di_d = vld ? dat : ob_val;
        rd_timeout_d = !vld;
      end
      DONE: state_d = phi2 ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      state_q <= IDLE;
      phi2_q <= 1'b0;
      cpu_di_q <= OPEN_BUS_VAL;
      rd_src_q <= NONE;
      conflict_q <= 1'b0;
      rd_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phi2_q <= phi2;
      cpu_di_q <= cpu_di_d;
      rd_src_q <= rd_src_d;
      conflict_q <= conflict_d;
      rd_timeout_q <= rd_timeout_d;
    end
  end
  assign cpu_di = cpu_di_q;
  assign rd_src = rd_src_q;
  assign conflict = conflict_q;
  assign rd_timeout = rd_timeout_q;
endmodule

// File: tb/tb_oric_cpu_rdmux.sv
// tb_oric_cpu_rdmux: directed and random bus phases against a phase-level model, open-bus hold and 0xFF variants.
module tb_oric_cpu_rdmux;
  logic clk = 0, rst = 1, phi2 = 0, phi2_en = 0, cpu_rw = 1;
  logic [7:0] cpu_do = 0, src_sel = 0, src_valid = 0;
  logic [63:0] src_data = 0;
  logic [7:0] di_h, di_0;
  logic [3:0] src_h, src_0;
  logic conf_h, conf_0, to_h, to_0;
  int checks = 0, errors = 0;
  int dly [8];
  logic [7:0] dat [8];
  logic [7:0] prev_h = 8'hFF, prev_0 = 8'hFF;
  always #5 clk = ~clk;
  oric_cpu_rdmux dut_h (
    .CLK_IN(clk), .RESET(rst), .phi2(phi2), .phi2_en(phi2_en), .cpu_rw(cpu_rw), .cpu_do(cpu_do),
    .src_sel(src_sel), .src_valid(src_valid), .src_data(src_data),
    .cpu_di(di_h), .rd_src(src_h), .conflict(conf_h), .rd_timeout(to_h)
  );
  oric_cpu_rdmux #(.OPEN_BUS_HOLD(0)) dut_0 (
    .CLK_IN(clk), .RESET(rst), .phi2(phi2), .phi2_en(phi2_en), .cpu_rw(cpu_rw), .cpu_do(cpu_do),
    .src_sel(src_sel), .src_valid(src_valid), .src_data(src_data),
    .cpu_di(di_0), .rd_src(src_0), .conflict(conf_0), .rd_timeout(to_0)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic clear_srcs();
    for (int i = 0; i < 8; i++) begin
      dly[i] = -1;
      dat[i] = 8'($urandom);
    end
  endtask
  task automatic drive(input int t, input int len, input int e, input bit rw, input logic [7:0] dout, input logic [7:0] sel);
    phi2 = t < len;
    phi2_en = (t < len) ? (t == e) : ($urandom_range(0, 3) == 0);
    cpu_rw = rw;
    cpu_do = dout;
    src_sel = (t == 0) ? sel : 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      src_valid[i] = t < len && dly[i] >= 0 && t >= dly[i];
      src_data[i*8 +: 8] = (dly[i] >= 0 && t > dly[i]) ? ~dat[i] : dat[i];
    end
  endtask
  task automatic check_reset_vals();
    check("rst_cpu_di", di_h, 8'hFF);
    check("rst_cpu_di_ff", di_0, 8'hFF);
    check("rst_rd_src", src_h, 4'hF);
    check("rst_rd_src_ff", src_0, 4'hF);
    check("rst_conflict", conf_h, 0);
    check("rst_rd_timeout", to_h, 0);
    check("rst_rd_timeout_ff", to_0, 0);
  endtask
  task automatic run_phase(input bit rw, input logic [7:0] dout, input logic [7:0] sel, input int len, input int e, input int lo);
    int k, ev, to, c;
    logic [3:0] xs;
    logic [7:0] nh, n0;
    bit cf;
    k = -1; ev = 0; to = -1; xs = 4'hF;
    for (int i = 0; i < 8; i++) if (sel[i] && k < 0) k = i;
    cf = rw && $countones(sel) > 1;
    if (!rw) begin
      nh = dout;
      n0 = dout;
    end else if (k < 0) begin
      nh = prev_h;
      n0 = 8'hFF;
    end else begin
      xs = 4'(k);
      if (dly[k] >= 0 && (e >= 0 ? dly[k] <= e : dly[k] < len)) begin
        ev = dly[k];
        nh = dat[k];
        n0 = dat[k];
      end else begin
        ev = e >= 0 ? e : len;
        to = ev;
        nh = prev_h;
        n0 = 8'hFF;
      end
    end
    for (int t = 0; t <= len + lo; t++) begin
      @(negedge clk);
      if (t > 0) begin
        c = t - 1;
        check("cpu_di_hold", di_h, c >= ev ? nh : prev_h);
        check("cpu_di_ff", di_0, c >= ev ? n0 : prev_0);
        check("rd_src", src_h, xs);
        check("rd_src_ff", src_0, xs);
        check("conflict", conf_h, c == 0 && cf);
        check("conflict_ff", conf_0, c == 0 && cf);
        check("rd_timeout", to_h, c == to);
        check("rd_timeout_ff", to_0, c == to);
      end
      if (t < len + lo) drive(t, len, e, rw, dout, sel);
    end
    prev_h = nh;
    prev_0 = n0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 0;
    clear_srcs(); dly[5] = 2; dat[5] = 8'hA5;
    run_phase(1, 0, 8'h20, 6, 4, 2);
    clear_srcs(); dly[1] = 1; dly[3] = 1; dat[1] = 8'h11; dat[3] = 8'h33;
    run_phase(1, 0, 8'h0A, 6, 4, 2);
    clear_srcs(); dly[2] = 0; dat[2] = 8'h42;
    run_phase(1, 0, 8'h04, 4, 2, 2);
    clear_srcs();
    run_phase(1, 0, 8'h08, 5, 3, 2);
    run_phase(0, 8'h5C, 8'h00, 4, 2, 2);
    run_phase(1, 0, 8'h00, 4, 2, 2);
    clear_srcs(); dly[0] = 1; dat[0] = 8'h77;
    run_phase(1, 0, 8'h01, 6, 5, 2);
    clear_srcs();
    run_phase(1, 0, 8'h10, 3, -1, 2);
    clear_srcs();
    for (int t = 0; t <= 3; t++) begin
      @(negedge clk);
      if (t == 2) check("wait_rd_src", src_h, 4'h3);
      if (t == 3) check_reset_vals();
      drive(t, 3, -1, 1, 0, 8'h08);
      rst = (t == 2);
    end
    prev_h = 8'hFF;
    prev_0 = 8'hFF;
    clear_srcs(); dly[6] = 1; dat[6] = 8'h3C;
    run_phase(1, 0, 8'h40, 4, 3, 1);
    for (int n = 0; n < 200; n++) begin
      int len, e, r;
      for (int i = 0; i < 8; i++) begin
        r = $urandom_range(0, 9);
        dly[i] = r < 2 ? -1 : r - 2;
        dat[i] = 8'($urandom);
      end
      len = $urandom_range(2, 8);
      e = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, len - 1);
      run_phase($urandom_range(0, 3) != 0, 8'($urandom), ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom & $urandom),
                len, e, $urandom_range(1, 3));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
